// File: rtl/timer_intr_ctrl_pkg.sv
// Shared constants for the timer/interrupt controller: register word offsets,
// CTRL bit positions, interrupt FSM encodings and the timer cause code.
package timer_intr_pkg;

  // Register word index, taken from Daddr[4:2]
  localparam logic [2:0] RegCtrl    = 3'd0;
  localparam logic [2:0] RegCount   = 3'd1;
  localparam logic [2:0] RegCompare = 3'd2;
  localparam logic [2:0] RegPend    = 3'd3;
  localparam logic [2:0] RegMask    = 3'd4;
  localparam logic [2:0] RegEoi     = 3'd5;

  // CTRL bit positions
  localparam int unsigned CtrlTen  = 0;
  localparam int unsigned CtrlAuto = 1;
  localparam int unsigned CtrlGie  = 2;

  // Interrupt FSM encodings
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReq     = 2'd1;
  localparam logic [1:0] StService = 2'd2;

  // Timer has cause code 0; external line k reports k+1
  localparam logic [3:0] CauseTimer = 4'd0;

endpackage

// File: rtl/timer_intr_ctrl_if.sv
// CPU data-port and interrupt handshake signals of the timer/interrupt controller.
interface timer_intr_ctrl_if #(
  parameter int unsigned NUM_EXT = 4
);
  logic [31:0]        Daddr;
  logic [31:0]        Dwrite;
  logic               Wmem;
  logic               Sel;
  logic [31:0]        Dread;
  logic [NUM_EXT-1:0] ExtIrq;
  logic               Intr;
  logic               Inta;
  logic [3:0]         IntCause;

  // CPU / system side
  modport master (
    output Daddr, Dwrite, Wmem, ExtIrq, Inta,
    input  Sel, Dread, Intr, IntCause
  );

  // Controller side
  modport slave (
    input  Daddr, Dwrite, Wmem, ExtIrq, Inta,
    output Sel, Dread, Intr, IntCause
  );
endinterface

// File: rtl/timer_intr_ctrl_irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous interrupt line, followed by a
// rising-edge detector that emits a single-cycle pulse.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);
  logic meta_q, sync_q, prev_q;

  // Synchronizer chain plus the delayed copy used for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse = sync_q & ~prev_q;
endmodule

// File: rtl/timer_intr_ctrl.sv
// Memory-mapped timer and interrupt controller on the CPU data bus. Provides a
// free-running/one-shot compare timer, edge-triggered external lines, pending
// and mask registers, and a request/acknowledge/EOI handshake towards the CPU.
module timer_intr_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int unsigned NUM_EXT   = 4
) (
  input logic             Clk,
  input logic             Clrn,
  timer_intr_ctrl_if.slave bus
);
  import timer_intr_pkg::*;

  logic [2:0]         ctrl_q, ctrl_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        compare_q, compare_d;
  logic [NUM_EXT:0]   pend_q, pend_d, mask_q, mask_d;
  logic [1:0]         state_q, state_d;
  logic               intr_q, intr_d;
  logic [3:0]         cause_q, cause_d, cause_sel;
  logic [NUM_EXT-1:0] ext_pulse;
  logic [NUM_EXT:0]   active;
  logic [2:0]         word_idx;
  logic               wr_en, match, req_cond;
  logic [31:0]        rdata;

  for (genvar k = 0; k < NUM_EXT; k++) begin : g_ext
    irq_sync_edge u_sync (
      .clk      (Clk),
      .rst      (Clrn),
      .async_in (bus.ExtIrq[k]),
      .pulse    (ext_pulse[k])
    );
  end

  assign bus.Sel  = (bus.Daddr[31:5] == BASE_ADDR[31:5]);
  assign word_idx = bus.Daddr[4:2];
  assign wr_en    = bus.Sel & bus.Wmem;
  assign match    = ctrl_q[CtrlTen] & (count_q == compare_q);
  assign active   = pend_q & mask_q;
  assign req_cond = ctrl_q[CtrlGie] & (|active);

  // Register read mux; unmapped words and unused bits read as 0
  always_comb begin
    rdata = '0;
    if (bus.Sel) begin
      case (word_idx)
        RegCtrl:    rdata[2:0]       = ctrl_q;
        RegCount:   rdata            = count_q;
        RegCompare: rdata            = compare_q;
        RegPend:    rdata[NUM_EXT:0] = pend_q;
        RegMask:    rdata[NUM_EXT:0] = mask_q;
        default:    rdata            = '0;
      endcase
    end
  end

  // Timer, register writes and pending set/clear (hardware set beats W1C)
  always_comb begin
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    compare_d = compare_q;
    mask_d    = mask_q;
    if (wr_en && word_idx == RegCount) begin
      count_d = bus.Dwrite;
    end else if (match) begin
      count_d = ctrl_q[CtrlAuto] ? '0 : count_q;
    end else if (ctrl_q[CtrlTen]) begin
      count_d = count_q + 32'd1;
    end
    if (wr_en && word_idx == RegCtrl) begin
      ctrl_d = bus.Dwrite[2:0];
    end else if (match && !ctrl_q[CtrlAuto]) begin
      ctrl_d[CtrlTen] = 1'b0;
    end
    if (wr_en && word_idx == RegCompare) compare_d = bus.Dwrite;
    if (wr_en && word_idx == RegMask)    mask_d    = bus.Dwrite[NUM_EXT:0];
    pend_d = pend_q;
    if (wr_en && word_idx == RegPend) pend_d = pend_q & ~bus.Dwrite[NUM_EXT:0];
    pend_d = pend_d | {ext_pulse, match};
  end

  // Lowest enabled pending index wins, so the timer has top priority
  always_comb begin
    cause_sel = CauseTimer;
    for (int i = NUM_EXT; i >= 0; i--) begin
      if (active[i]) cause_sel = 4'(i);
    end
  end

  // Interrupt handshake FSM
  always_comb begin
    state_d = state_q;
    intr_d  = intr_q;
    cause_d = cause_q;
    case (state_q)
      StIdle: begin
        if (req_cond) begin
          state_d = StReq;
          intr_d  = 1'b1;
        end
      end
      StReq: begin
        if (!req_cond) begin
          state_d = StIdle;
          intr_d  = 1'b0;
        end else if (bus.Inta) begin
          state_d = StService;
          intr_d  = 1'b0;
          cause_d = cause_sel;
        end
      end
      StService: begin
        if (wr_en && word_idx == RegEoi) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        intr_d  = 1'b0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge Clk or posedge Clrn) begin
    if (Clrn) begin
      ctrl_q    <= '0;
      count_q   <= '0;
      compare_q <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      state_q   <= StIdle;
      intr_q    <= 1'b0;
      cause_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      state_q   <= state_d;
      intr_q    <= intr_d;
      cause_q   <= cause_d;
    end
  end

  assign bus.Dread    = rdata;
  assign bus.Intr     = intr_q;
  assign bus.IntCause = cause_q;
endmodule

// File: tb/tb_timer_intr_ctrl.sv
// Bench for timer_intr_ctrl: directed stimulus, a behavioural model checked on
// every falling edge, and literal expectations at the interesting points.
module tb_timer_intr_ctrl;
  localparam int unsigned NE = 4;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int PhIdle = 0;
  localparam int PhReq  = 1;
  localparam int PhSvc  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  timer_intr_ctrl_if #(.NUM_EXT(NE)) bus ();

  timer_intr_ctrl #(.BASE_ADDR(BASE), .NUM_EXT(NE)) dut (
    .Clk  (clk),
    .Clrn (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  logic [31:0] m_count, m_cmp;
  bit          m_ten, m_auto, m_gie;
  bit          m_pend[0:NE];
  bit          m_mask[0:NE];
  bit          h1[NE], h2[NE], h3[NE];  // line samples at edges n-1, n-2, n-3
  int          m_phase;
  logic [3:0]  m_cause;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_count = '0; m_cmp = '0; m_ten = 0; m_auto = 0; m_gie = 0;
    for (int i = 0; i <= NE; i++) begin m_pend[i] = 0; m_mask[i] = 0; end
    for (int k = 0; k < NE; k++) begin h1[k] = 0; h2[k] = 0; h3[k] = 0; end
    m_phase = PhIdle;
    m_cause = '0;
  endtask

  function automatic logic [31:0] pend_word();
    logic [31:0] w = '0;
    for (int i = 0; i <= NE; i++) w[i] = m_pend[i];
    return w;
  endfunction

  function automatic logic [31:0] mask_word();
    logic [31:0] w = '0;
    for (int i = 0; i <= NE; i++) w[i] = m_mask[i];
    return w;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return '0;
    case (a[4:2])
      3'd0: return {29'd0, m_gie, m_auto, m_ten};
      3'd1: return m_count;
      3'd2: return m_cmp;
      3'd3: return pend_word();
      3'd4: return mask_word();
      default: return '0;
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs currently applied
  task automatic model_step();
    bit match, we, any;
    bit set_b[0:NE];
    logic [2:0] idx;
    logic [3:0] low;
    match = m_ten && (m_count == m_cmp);
    we    = bus.Wmem && (bus.Daddr[31:5] == BASE[31:5]);
    idx   = bus.Daddr[4:2];
    any = 0; low = 0;
    for (int i = NE; i >= 0; i--) begin
      if (m_pend[i] && m_mask[i]) begin any = 1; low = 4'(i); end
    end
    case (m_phase)
      PhIdle: if (m_gie && any) m_phase = PhReq;
      PhReq: begin
        if (!(m_gie && any)) m_phase = PhIdle;
        else if (bus.Inta) begin m_phase = PhSvc; m_cause = low; end
      end
      default: if (we && idx == 3'd5) m_phase = PhIdle;
    endcase
    set_b[0] = match;
    for (int k = 0; k < NE; k++) begin
      set_b[k+1] = h2[k] && !h3[k];
      h3[k] = h2[k]; h2[k] = h1[k]; h1[k] = bus.ExtIrq[k];
    end
    for (int i = 0; i <= NE; i++) begin
      if (set_b[i]) m_pend[i] = 1;
      else if (we && idx == 3'd3 && bus.Dwrite[i]) m_pend[i] = 0;
      if (we && idx == 3'd4) m_mask[i] = bus.Dwrite[i];
    end
    if (we && idx == 3'd2) m_cmp = bus.Dwrite;
    if (we && idx == 3'd1) m_count = bus.Dwrite;
    else if (match) m_count = m_auto ? 32'd0 : m_count;
    else if (m_ten) m_count = m_count + 32'd1;
    if (we && idx == 3'd0) begin
      m_ten = bus.Dwrite[0]; m_auto = bus.Dwrite[1]; m_gie = bus.Dwrite[2];
    end else if (match && !m_auto) begin
      m_ten = 0;
    end
  endtask

  // Compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    check("sel", {31'd0, bus.Sel}, {31'd0, bus.Daddr[31:5] == BASE[31:5]});
    check("dread", bus.Dread, model_read(bus.Daddr));
    check("intr", {31'd0, bus.Intr}, {31'd0, m_phase == PhReq});
    check("intcause", {28'd0, bus.IntCause}, {28'd0, m_cause});
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Daddr = a; bus.Dwrite = d; bus.Wmem = 1'b1;
    tick();
    bus.Wmem = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.Daddr = a;
    #1;
    check(name, bus.Dread, exp);
  endtask

  task automatic inta_pulse();
    bus.Inta = 1'b1;
    tick();
    bus.Inta = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.Daddr = '0; bus.Dwrite = '0; bus.Wmem = 1'b0; bus.Inta = 1'b0; bus.ExtIrq = '0;
    model_reset();

    // 1: reset values and decode boundary
    do_reset();
    for (int i = 0; i < 8; i++) rd_check("reset_read", BASE + 32'(i * 4), 32'd0);
    check("sel_in_block", {31'd0, bus.Sel}, 32'd1);
    bus.Daddr = 32'h120;
    #1;
    check("sel_out_block", {31'd0, bus.Sel}, 32'd0);
    check("dread_out_block", bus.Dread, 32'd0);
    check("reset_intr", {31'd0, bus.Intr}, 32'd0);

    // 2: one-shot compare
    do_reset();
    wr(32'h108, 32'd5);
    wr(32'h110, 32'd1);
    wr(32'h100, 32'h5);
    repeat (5) tick();
    rd_check("oneshot_count5", 32'h104, 32'd5);
    rd_check("oneshot_pend_before", 32'h10C, 32'd0);
    tick();
    rd_check("oneshot_pend_set", 32'h10C, 32'd1);
    rd_check("oneshot_ten_clear", 32'h100, 32'h4);
    check("oneshot_intr_low", {31'd0, bus.Intr}, 32'd0);
    tick();
    check("oneshot_intr_high", {31'd0, bus.Intr}, 32'd1);
    repeat (3) tick();
    rd_check("oneshot_count_hold", 32'h104, 32'd5);

    // 3: auto-reload, set beats W1C on the match cycle
    do_reset();
    wr(32'h108, 32'd5);
    wr(32'h110, 32'd1);
    wr(32'h100, 32'h7);
    repeat (7) tick();
    wr(32'h10C, 32'd1);
    rd_check("auto_w1c_clear", 32'h10C, 32'd0);
    repeat (3) tick();
    wr(32'h10C, 32'd1);
    rd_check("auto_set_wins", 32'h10C, 32'd1);
    rd_check("auto_reload", 32'h104, 32'd0);
    repeat (6) tick();
    rd_check("auto_reload_again", 32'h104, 32'd0);

    // 4: two external lines, handshake, EOI re-request
    do_reset();
    wr(32'h110, 32'h6);
    wr(32'h100, 32'h4);
    bus.ExtIrq = 4'b0011;
    tick();
    bus.ExtIrq = '0;
    tick();
    rd_check("ext_pend_early", 32'h10C, 32'd0);
    tick();
    rd_check("ext_pend", 32'h10C, 32'h6);
    tick();
    check("ext_intr", {31'd0, bus.Intr}, 32'd1);
    inta_pulse();
    check("ext_cause1", {28'd0, bus.IntCause}, 32'd1);
    check("ext_intr_ack", {31'd0, bus.Intr}, 32'd0);
    wr(32'h114, 32'hDEAD);
    tick();
    check("ext_rereq", {31'd0, bus.Intr}, 32'd1);
    wr(32'h10C, 32'h2);
    inta_pulse();
    check("ext_cause2", {28'd0, bus.IntCause}, 32'd2);

    // 5: timer priority, Inta ignored in SERVICE
    do_reset();
    wr(32'h110, 32'h9);
    wr(32'h108, 32'd2);
    wr(32'h100, 32'h5);
    bus.ExtIrq = 4'b0100;
    tick();
    bus.ExtIrq = '0;
    tick();
    tick();
    rd_check("prio_pend", 32'h10C, 32'h9);
    tick();
    check("prio_intr", {31'd0, bus.Intr}, 32'd1);
    inta_pulse();
    check("prio_cause0", {28'd0, bus.IntCause}, 32'd0);
    wr(32'h10C, 32'h1);
    inta_pulse();
    check("svc_inta_cause", {28'd0, bus.IntCause}, 32'd0);
    tick();
    check("svc_inta_intr", {31'd0, bus.Intr}, 32'd0);
    wr(32'h114, 32'd0);
    tick();
    check("svc_eoi_rereq", {31'd0, bus.Intr}, 32'd1);
    inta_pulse();
    check("svc_cause3", {28'd0, bus.IntCause}, 32'd3);

    // 6: reset from SERVICE, line held high through release
    do_reset();
    wr(32'h110, 32'h2);
    wr(32'h108, 32'd100);
    wr(32'h100, 32'h5);
    bus.ExtIrq = 4'b0001;
    tick();
    bus.ExtIrq = '0;
    repeat (3) tick();
    inta_pulse();
    check("pre_reset_cause", {28'd0, bus.IntCause}, 32'd1);
    bus.Daddr = 32'h104;
    bus.ExtIrq = 4'b1000;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_intr", {31'd0, bus.Intr}, 32'd0);
    check("rst_cause", {28'd0, bus.IntCause}, 32'd0);
    check("rst_count", bus.Dread, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();
    rd_check("held_pend_early", 32'h10C, 32'd0);
    tick();
    rd_check("held_pend", 32'h10C, 32'h10);
    repeat (5) tick();
    rd_check("held_single", 32'h10C, 32'h10);
    bus.ExtIrq = '0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/timer_intr_ctrl.md
Name: timer_intr_ctrl

Overview:
- Memory-mapped timer and interrupt controller on the single-cycle CPU data bus, decoded in parallel with DATAMEM.
- Consumes the CPU data-port outputs: Daddr, Dwrite, Wmem.
- Returns read data plus a hit flag, which the CPU top uses to mux against the DATAMEM read data.
- Drives the CPU interrupt request through a request/acknowledge/end-of-interrupt handshake, which the exception/interrupt logic consumes.

Parameters:
- BASE_ADDR, 32'h0000_0100: register-block base address; bits [4:0] must be 0.
- NUM_EXT, 4: number of external interrupt lines, range 1..8.

Ports:
- Clk, in, 1: clock; all state updates on the rising edge.
- Clrn, in, 1: asynchronous reset, active-high (1 = reset), per the CPU-level port name.
- Daddr, in, 32: data address from the CPU.
- Dwrite, in, 32: write data from the CPU.
- Wmem, in, 1: write enable from the CPU.
- Sel, out, 1: combinational; 1 when Daddr[31:5] == BASE_ADDR[31:5].
- Dread, out, 32: combinational register read data; 0 when Sel = 0.
- ExtIrq, in, NUM_EXT: asynchronous external interrupt lines, rising-edge sensitive.
- Intr, out, 1: interrupt request to the CPU, registered.
- Inta, in, 1: CPU acknowledge, 1-cycle pulse.
- IntCause, out, 4: registered cause code latched at acknowledge. 0 = timer; k+1 = ExtIrq[k].

Behaviour:
- Register map, word index Daddr[4:2]:
  - 0 CTRL: [0] TEN, [1] AUTO, [2] GIE.
  - 1 COUNT.
  - 2 COMPARE.
  - 3 PEND: [0] timer, [NUM_EXT:1] external; read; write-1-to-clear.
  - 4 MASK: same layout; 1 = enabled.
  - 5 EOI: write-only, any value; reads 0.
  - 6..7: reads 0, writes ignored.
- Writes occur at the rising edge when Sel & Wmem. Unused register bits read 0.
- Reset: all registers 0, synchronizers 0, FSM IDLE, Intr = 0, IntCause = 0.
- Timer:
  - While TEN = 1, COUNT increments by 1 per cycle and wraps 32'hFFFF_FFFF -> 0.
  - Match = TEN & (COUNT == COMPARE), using the registered COUNT.
  - On match, at the next edge: PEND[0] is set; COUNT loads 0 if AUTO = 1; otherwise TEN clears and COUNT holds.
  - A CPU write to COUNT wins over increment/reload. A CTRL write wins over the TEN auto-clear.
- External lines:
  - Each line passes through a 2-flop synchronizer, then a rising-edge detect against a registered copy.
  - A line sampled high at edge t gives PEND[k+1] = 1 after edge t+2.
  - A line held high across reset release produces exactly one pending event.
- Set/clear priority: when a hardware set and a W1C hit the same bit in the same cycle, set wins.
- Interrupt FSM (states IDLE, REQ, SERVICE):
  - IDLE -> REQ when GIE & |(PEND & MASK); Intr = 1 from the next edge.
  - REQ -> IDLE if the qualifying condition vanishes before Inta (Intr drops).
  - REQ -> SERVICE on Inta: IntCause latches the lowest set index of PEND & MASK (timer highest priority); Intr = 0. The pending bit is not auto-cleared; software clears it via W1C.
  - SERVICE -> IDLE on an EOI write.
  - Inta in IDLE or SERVICE is ignored.
  - An EOI write in IDLE or REQ is ignored.
  - New pending events accumulate during SERVICE and are requested after EOI.
- Clrn mid-operation: returns immediately to reset values, including from REQ or SERVICE.

Decomposition:
- Shared package (timer_intr_pkg): register word offsets, CTRL bit positions, FSM state encodings (IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2), cause code for the timer (0).
- One sub-module: irq_sync_edge, a 2-flop synchronizer plus rising-edge pulse. It is instantiated NUM_EXT times.

Test Plan:
1. Reset, then read all registers at 0x100..0x11C -> all 0; Sel = 0 at 0x120 and Dread = 0.
2. COMPARE = 5, MASK = 1, CTRL = 3'b101 -> COUNT 0..5; PEND[0] = 1 one edge after COUNT == 5; Intr = 1 the next edge; COUNT stops at 5 with TEN = 0.
3. Same setup with AUTO = 1 (CTRL = 3'b111) -> COUNT reloads to 0 after the match and matches again every 6 cycles; a W1C to PEND on the match-set cycle leaves PEND[0] = 1.
4. MASK = 5'b00110 with GIE; pulse ExtIrq[0] and ExtIrq[1] in the same cycle -> PEND = 5'b00110 after 3 edges; Intr rises; Inta -> IntCause = 1, Intr = 0; EOI write with PEND still 5'b00110 -> Intr re-asserts in the cycle after EOI; after W1C 5'b00010 and Inta -> IntCause = 2.
5. Timer and ExtIrq[2] pending together, both masked -> IntCause = 0 at Inta; an Inta pulse in SERVICE leaves the state and IntCause unchanged.
6. Assert Clrn while in SERVICE with TEN = 1 -> all outputs 0 immediately; ExtIrq[3] held high through release -> a single PEND[4] set 3 edges after release.
